// File: rtl/lmi_ifill_bus.sv
// -----------------------------------------------------------------------------
// lmi_ifill_bus
//   Instruction-fill bus master. On a cache miss it issues the word reads of
//   one cache line (or a single word for an uncached fetch) on the local
//   memory read channel. Each returned beat goes back to the cache one cycle
//   later on IS_VAL/IS_DATA. Beats come back in the order the cache's burst
//   counter expects: critical-word-first or zero-first, and sequential-wrap
//   or interleaved.
//
// Parameters
//   BEATS   words per cache line (power of 2, 2..8)
//   MAXOUT  maximum granted-but-unreturned reads (1..3)
//
// Ports
//   CLK, RESET_D1_R_N   clock, asynchronous active-low reset
//   FILL_REQ            fill request, sampled only while idle
//   FILL_ADDR           fetch address (bits [1:0] ignored)
//   FILL_UNCACHED       single-word read of FILL_ADDR
//   MEMSEQUENTIAL       1 = sequential wrap order, 0 = interleaved order
//   MEMZEROFIRST        1 = burst starts at beat 0, 0 = critical word first
//   FILL_BUSY           fill in progress
//   IS_VAL / IS_DATA    beat strobe and data to the cache (registered)
//   FILL_ERR            pulse coincident with a beat that returned an error
//   MEM_REQ / MEM_ADDR  read address channel, held until MEM_GNT
//   MEM_GNT             address accepted this cycle
//   MEM_RVALID / MEM_RDATA / MEM_RERR   in-order read response
// -----------------------------------------------------------------------------
module lmi_ifill_bus #(
  parameter int BEATS  = 4,
  parameter int MAXOUT = 2
) (
  input  logic        CLK,
  input  logic        RESET_D1_R_N,
  input  logic        FILL_REQ,
  input  logic [31:0] FILL_ADDR,
  input  logic        FILL_UNCACHED,
  input  logic        MEMSEQUENTIAL,
  input  logic        MEMZEROFIRST,
  output logic        FILL_BUSY,
  output logic        IS_VAL,
  output logic [31:0] IS_DATA,
  output logic        FILL_ERR,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_RERR
);

  // Offset width and beat-count width; one extra bit so N = BEATS fits.
  localparam int OW = $clog2(BEATS);
  localparam int CW = OW + 1;

  localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
  localparam logic [1:0]    MAXOUT_C = 2'(MAXOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Request context captured when a fill is accepted.
  logic [31:0]   r_base;
  logic [OW-1:0] r_start;
  logic          r_seq;
  logic [CW-1:0] r_total;

  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_received;
  logic [1:0]    r_outstanding;

  logic          r_is_val;
  logic [31:0]   r_is_data;
  logic          r_fill_err;

  logic          w_accept;
  logic          w_mem_req;
  logic          w_fire;
  logic          w_rsp;
  logic [OW-1:0] w_k;
  logic [OW-1:0] w_offset;
  logic [31:0]   w_off_addr;
  logic [31:0]   w_line_base;
  logic [OW-1:0] w_beat_bits;
  logic          w_unused_addr_lsbs;

  // Byte-lane bits of the fetch address carry no meaning for word reads.
  assign w_unused_addr_lsbs = ^FILL_ADDR[1:0];

  assign w_beat_bits = FILL_ADDR[OW+1:2];
  assign w_line_base = {FILL_ADDR[31:OW+2], {OW{1'b0}}, 2'b00};

  assign w_accept = (r_state == S_IDLE) && FILL_REQ;

  // Beat offset for the next beat to issue; OW-bit arithmetic wraps the
  // sequential order at the line boundary by truncation.
  assign w_k      = r_issued[OW-1:0];
  assign w_offset = r_seq ? (r_start + w_k) : (r_start ^ w_k);
  assign w_off_addr = {{(30-OW){1'b0}}, w_offset, 2'b00};

  // Request is a pure function of registers so it cannot combinationally
  // loop through the memory's grant logic.
  assign w_mem_req = (r_state == S_ISSUE) && (r_issued < r_total) &&
                     (r_outstanding < MAXOUT_C);
  assign w_fire    = w_mem_req && MEM_GNT;

  // Responses only count while a fill is actually waiting for them.
  assign w_rsp = MEM_RVALID && ((r_state == S_ISSUE) || (r_state == S_DRAIN));

  // NOTE: every state element uses non-blocking assignments so all registers
  // update together from the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next-state value is given a default before the case so every
  // path assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (FILL_REQ) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_fire && ((r_issued + CW'(1)) == r_total)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rsp && ((r_received + CW'(1)) == r_total)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fill context. For an uncached fetch the whole word address is the base
  // and the start offset is forced to 0, so the single beat hits FILL_ADDR.
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_base  <= '0;
      r_start <= '0;
      r_seq   <= 1'b0;
      r_total <= '0;
    end else if (w_accept) begin
      r_base  <= FILL_UNCACHED ? {FILL_ADDR[31:2], 2'b00} : w_line_base;
      r_start <= (MEMZEROFIRST || FILL_UNCACHED) ? '0 : w_beat_bits;
      r_seq   <= MEMSEQUENTIAL;
      r_total <= FILL_UNCACHED ? CW'(1) : BEATS_C;
    end
  end

  // Issue/return bookkeeping. A grant and a response in the same cycle
  // leave the outstanding count unchanged.
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
    end else if (w_accept) begin
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_fire) r_issued   <= r_issued + CW'(1);
      if (w_rsp)  r_received <= r_received + CW'(1);
      unique case ({w_fire, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Beat return to the cache, one cycle after the memory response. Error
  // beats are still delivered; the burst runs to completion.
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_is_val   <= 1'b0;
      r_is_data  <= '0;
      r_fill_err <= 1'b0;
    end else begin
      r_is_val   <= w_rsp;
      r_fill_err <= w_rsp && MEM_RERR;
      if (w_rsp) r_is_data <= MEM_RDATA;
    end
  end

  assign FILL_BUSY = (r_state != S_IDLE);
  assign IS_VAL    = r_is_val;
  assign IS_DATA   = r_is_data;
  assign FILL_ERR  = r_fill_err;
  assign MEM_REQ   = w_mem_req;
  assign MEM_ADDR  = (r_state == S_ISSUE) ? (r_base | w_off_addr) : '0;

endmodule

// File: tb/tb_lmi_ifill_bus.sv
// -----------------------------------------------------------------------------
// tb_lmi_ifill_bus
//   Directed bench for lmi_ifill_bus (BEATS=4, MAXOUT=2). A small in-order
//   memory responder with programmable grant hold-off, response latency and
//   error injection sits on the read channel. A negedge monitor records the
//   per-cycle bus activity of each fill; the expected address orders and
//   cycle positions below are hand-derived.
// -----------------------------------------------------------------------------
module tb_lmi_ifill_bus;

  logic        CLK = 1'b0;
  logic        RESET_D1_R_N;
  logic        FILL_REQ;
  logic [31:0] FILL_ADDR;
  logic        FILL_UNCACHED;
  logic        MEMSEQUENTIAL;
  logic        MEMZEROFIRST;
  logic        FILL_BUSY;
  logic        IS_VAL;
  logic [31:0] IS_DATA;
  logic        FILL_ERR;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        MEM_RERR;

  lmi_ifill_bus #(.BEATS(4), .MAXOUT(2)) dut (
    .CLK           (CLK),
    .RESET_D1_R_N  (RESET_D1_R_N),
    .FILL_REQ      (FILL_REQ),
    .FILL_ADDR     (FILL_ADDR),
    .FILL_UNCACHED (FILL_UNCACHED),
    .MEMSEQUENTIAL (MEMSEQUENTIAL),
    .MEMZEROFIRST  (MEMZEROFIRST),
    .FILL_BUSY     (FILL_BUSY),
    .IS_VAL        (IS_VAL),
    .IS_DATA       (IS_DATA),
    .FILL_ERR      (FILL_ERR),
    .MEM_REQ       (MEM_REQ),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_GNT       (MEM_GNT),
    .MEM_RVALID    (MEM_RVALID),
    .MEM_RDATA     (MEM_RDATA),
    .MEM_RERR      (MEM_RERR)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] DMASK = 32'hDEAD_0000;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder and monitor (all activity on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  rd_t rq[$];
  int  cyc       = 0;
  int  gnt_wait  = 0;
  int  lat       = 1;
  int  err_beat  = -1;
  int  rv_count  = 0;
  int  n_err_cyc = 0;
  bit  stray     = 1'b0;

  logic        h_req[$];
  logic        h_busy[$];
  logic        h_gnt[$];
  logic        h_rv[$];
  logic [31:0] h_addr[$];
  logic [31:0] b_data[$];
  logic        b_err[$];

  always @(negedge CLK) begin : model
    logic g;
    rd_t  e;
    h_req.push_back(MEM_REQ);
    h_addr.push_back(MEM_ADDR);
    h_busy.push_back(FILL_BUSY);
    if (IS_VAL) begin
      b_data.push_back(IS_DATA);
      b_err.push_back(FILL_ERR);
    end
    if (FILL_ERR) n_err_cyc++;
    if (!RESET_D1_R_N) begin
      rq.delete();
      MEM_GNT    = 1'b0;
      MEM_RVALID = 1'b0;
      MEM_RERR   = 1'b0;
      MEM_RDATA  = '0;
      h_gnt.push_back(1'b0);
      h_rv.push_back(1'b0);
    end else begin
      MEM_RVALID = 1'b0;
      MEM_RERR   = 1'b0;
      if (stray) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'h0BAD_0BAD;
        stray      = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = rq[0].addr ^ DMASK;
        MEM_RERR   = (rv_count == err_beat);
        rv_count++;
        void'(rq.pop_front());
      end
      g = 1'b1;
      if (MEM_REQ && gnt_wait > 0) begin
        g = 1'b0;
        gnt_wait--;
      end
      MEM_GNT = g;
      if (MEM_REQ && g) begin
        e.addr = MEM_ADDR;
        e.due  = cyc + lat;
        rq.push_back(e);
      end
      h_gnt.push_back(MEM_REQ && g);
      h_rv.push_back(MEM_RVALID);
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  typedef logic [31:0] addr4_t [4];
  addr4_t ea;

  function automatic logic at(input logic q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 1'bx;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_logs();
    h_req.delete();  h_busy.delete(); h_gnt.delete();
    h_rv.delete();   h_addr.delete(); b_data.delete(); b_err.delete();
    cyc = 0; rv_count = 0; n_err_cyc = 0;
  endtask

  // Log index 0 is the cycle in which FILL_REQ is presented; index 1 is the
  // first cycle after the sampling edge. Returns during index 1.
  task automatic fill(input logic [31:0] a, input bit unc, input bit seq,
                      input bit zf, input bit hold);
    tick();
    clear_logs();
    FILL_ADDR     = a;
    FILL_UNCACHED = unc;
    MEMSEQUENTIAL = seq;
    MEMZEROFIRST  = zf;
    FILL_REQ      = 1'b1;
    tick();
    if (!hold) FILL_REQ = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (FILL_BUSY !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic check_burst(input string tag, input addr4_t exp_a, input int n);
    logic [31:0] ga[$];
    for (int i = 0; i < h_gnt.size(); i++)
      if (h_gnt[i]) ga.push_back(h_addr[i]);
    check({tag, "_ngnt"},  ga.size(),     n);
    check({tag, "_nbeat"}, b_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ga.size())     check($sformatf("%s_addr%0d", tag, i), ga[i], exp_a[i]);
      if (i < b_data.size()) check($sformatf("%s_data%0d", tag, i), b_data[i], exp_a[i] ^ DMASK);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int cnt;
    int last_v;
    int r_idx;

    RESET_D1_R_N  = 1'b0;
    FILL_REQ      = 1'b0;
    FILL_ADDR     = '0;
    FILL_UNCACHED = 1'b0;
    MEMSEQUENTIAL = 1'b1;
    MEMZEROFIRST  = 1'b0;
    MEM_GNT       = 1'b0;
    MEM_RVALID    = 1'b0;
    MEM_RDATA     = '0;
    MEM_RERR      = 1'b0;

    // Reset values
    #1;
    check("rst_busy", FILL_BUSY, 1'b0);
    check("rst_isval", IS_VAL, 1'b0);
    check("rst_isdata", IS_DATA, 32'h0);
    check("rst_err", FILL_ERR, 1'b0);
    check("rst_req", MEM_REQ, 1'b0);
    check("rst_addr", MEM_ADDR, 32'h0);
    repeat (3) tick();
    RESET_D1_R_N = 1'b1;
    tick();
    check("idle_busy", FILL_BUSY, 1'b0);
    check("idle_req", MEM_REQ, 1'b0);

    // Stray response while idle is ignored
    stray = 1'b1;
    tick();
    tick();
    check("stray_isval", IS_VAL, 1'b0);
    check("stray_busy", FILL_BUSY, 1'b0);

    // 1: cached, sequential, critical first, s=2
    fill(32'h0000_1238, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("seq");
    repeat (2) tick();
    ea = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
    check_burst("seq", ea, 4);
    check("seq_busy0", at(h_busy, 0), 1'b0);
    check("seq_busy1", at(h_busy, 1), 1'b1);
    check("seq_req1", at(h_req, 1), 1'b1);
    cnt = 0;
    for (int i = 0; i < h_busy.size(); i++) if (h_busy[i]) cnt++;
    check("seq_busy_cycles", cnt, 6);
    last_v = -1;
    for (int i = 0; i < h_gnt.size(); i++) if (h_rv[i]) last_v = i + 1;
    check("seq_last_val_busy", at(h_busy, last_v), 1'b1);
    check("seq_busy_drop", at(h_busy, last_v + 1), 1'b0);

    // 2: interleaved, s=1; mode inputs flipped mid-fill have no effect
    fill(32'h0000_2004, 1'b0, 1'b0, 1'b0, 1'b0);
    MEMSEQUENTIAL = 1'b1;
    MEMZEROFIRST  = 1'b1;
    wait_idle("ilv");
    repeat (2) tick();
    ea = '{32'h2004, 32'h2000, 32'h200C, 32'h2008};
    check_burst("ilv", ea, 4);

    // 2b: interleaved, zero first
    fill(32'h0000_2004, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("ilvz");
    repeat (2) tick();
    ea = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
    check_burst("ilvz", ea, 4);

    // 3: uncached single word
    fill(32'hA000_0014, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle("unc");
    repeat (2) tick();
    ea = '{32'hA000_0014, 32'h0, 32'h0, 32'h0};
    check_burst("unc", ea, 1);
    cnt = 0;
    for (int i = 0; i < h_req.size(); i++) if (h_req[i]) cnt++;
    check("unc_req_cycles", cnt, 1);
    r_idx = -1;
    for (int i = 0; i < h_rv.size(); i++) if (h_rv[i] && r_idx < 0) r_idx = i;
    check("unc_busy_r1", at(h_busy, r_idx + 1), 1'b1);
    check("unc_busy_r2", at(h_busy, r_idx + 2), 1'b0);

    // 4: back-pressure: grant withheld 3 cycles, responses 4 cycles after grant
    gnt_wait = 3;
    lat      = 4;
    fill(32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_idle("bp");
    repeat (2) tick();
    lat = 1;
    ea = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    check_burst("bp", ea, 4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_req_hold%0d", i), at(h_req, i), 1'b1);
      check($sformatf("bp_addr_hold%0d", i), (i < h_addr.size()) ? h_addr[i] : 32'hx, 32'h3000);
    end
    check("bp_gnt3", at(h_gnt, 3), 1'b0);
    check("bp_gnt4", at(h_gnt, 4), 1'b1);
    check("bp_req_full6", at(h_req, 6), 1'b0);
    check("bp_req_full8", at(h_req, 8), 1'b0);
    check("bp_rv8", at(h_rv, 8), 1'b1);
    check("bp_req_again9", at(h_req, 9), 1'b1);

    // 5: error on beat 2, low address bits set and ignored (s=2)
    err_beat = 2;
    fill(32'h0000_400B, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("err");
    repeat (2) tick();
    err_beat = -1;
    ea = '{32'h4008, 32'h400C, 32'h4000, 32'h4004};
    check_burst("err", ea, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("err_flag%0d", i), (i < b_err.size()) ? b_err[i] : 1'bx, (i == 2));
    check("err_pulses", n_err_cyc, 1);

    // 6: FILL_REQ held high through the fill
    fill(32'h0000_5008, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle("hold1");
    tick();
    FILL_REQ = 1'b0;
    wait_idle("hold2");
    repeat (2) tick();
    cnt = 0;
    for (int i = 0; i < 7 && i < h_gnt.size(); i++) if (h_gnt[i]) cnt++;
    check("hold_first_gnts", cnt, 4);
    check("hold_idle7", at(h_busy, 7), 1'b0);
    check("hold_busy8", at(h_busy, 8), 1'b1);
    cnt = 0;
    for (int i = 0; i < h_gnt.size(); i++) if (h_gnt[i]) cnt++;
    check("hold_total_gnts", cnt, 8);
    check("hold_total_beats", b_data.size(), 8);

    // 7: reset after the second grant, then a clean burst
    fill(32'h0000_6000, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check("mid_busy", FILL_BUSY, 1'b1);
    check("mid_isval", IS_VAL, 1'b1);
    RESET_D1_R_N = 1'b0;
    #1;
    check("arst_busy", FILL_BUSY, 1'b0);
    check("arst_isval", IS_VAL, 1'b0);
    check("arst_isdata", IS_DATA, 32'h0);
    check("arst_err", FILL_ERR, 1'b0);
    check("arst_req", MEM_REQ, 1'b0);
    check("arst_addr", MEM_ADDR, 32'h0);
    repeat (2) tick();
    RESET_D1_R_N = 1'b1;
    tick();
    fill(32'h0000_6000, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_idle("post");
    repeat (2) tick();
    ea = '{32'h6000, 32'h6004, 32'h6008, 32'h600C};
    check_burst("post", ea, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
